// File: rtl/acc_seq_core.sv
`default_nettype none
// ============================================================================
// acc_seq_core : multi-cycle accumulator machine (fetch / operand / execute)
// Revision     : 1.0
// ============================================================================
module acc_seq_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] ac,
  output logic [DATA_W-1:0] iru,
  output logic [DATA_W-1:0] irl,
  output logic              nflg,
  output logic              zflg,
  output logic              cflg,
  output logic              halted
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH_U = 3'd1;
  localparam logic [2:0] S_FETCH_L = 3'd2;
  localparam logic [2:0] S_OPER    = 3'd3;
  localparam logic [2:0] S_EXEC    = 3'd4;
  localparam logic [2:0] S_HALT    = 3'd5;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_LDA  = 4'h2;
  localparam logic [3:0] OP_STA  = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_ADDI = 4'h6;
  localparam logic [3:0] OP_AND  = 4'h7;
  localparam logic [3:0] OP_OR   = 4'h8;
  localparam logic [3:0] OP_XOR  = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_JN   = 4'hB;
  localparam logic [3:0] OP_JZ   = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ac_q, ac_d;
  logic [DATA_W-1:0] iru_q, iru_d;
  logic [DATA_W-1:0] irl_q, irl_d;
  logic [DATA_W-1:0] opr_q, opr_d;
  logic              nflg_q, nflg_d;
  logic              zflg_q, zflg_d;
  logic              cflg_q, cflg_d;

  logic [3:0]        opcode;
  logic              is_mem_op;
  logic [ADDR_W-1:0] irl_addr;
  logic [DATA_W:0]   sum_ext;
  logic [DATA_W:0]   diff_ext;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] ac_new;
  logic              ac_wr;

  assign opcode = iru_q[3:0];

  always_comb begin
    case (opcode)
      OP_LDA, OP_STA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: is_mem_op = 1'b1;
      default:                                               is_mem_op = 1'b0;
    endcase
  end

  // Operand word doubles as both memory address and jump target.
  generate
    if (ADDR_W <= DATA_W) begin : g_addr_trunc
      assign irl_addr = irl_q[ADDR_W-1:0];
    end else begin : g_addr_ext
      assign irl_addr = {{(ADDR_W-DATA_W){1'b0}}, irl_q};
    end
  endgenerate

  assign alu_b    = (opcode == OP_ADDI) ? irl_q : opr_q;
  assign sum_ext  = {1'b0, ac_q} + {1'b0, alu_b};
  assign diff_ext = {1'b0, ac_q} - {1'b0, opr_q};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ac_q    <= '0;
      iru_q   <= '0;
      irl_q   <= '0;
      opr_q   <= '0;
      nflg_q  <= 1'b0;
      zflg_q  <= 1'b0;
      cflg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ac_q    <= ac_d;
      iru_q   <= iru_d;
      irl_q   <= irl_d;
      opr_q   <= opr_d;
      nflg_q  <= nflg_d;
      zflg_q  <= zflg_d;
      cflg_q  <= cflg_d;
    end
  end

  // Every transfer state has mem_req high, so ack alone marks completion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (run)     state_d = S_FETCH_U;
      S_FETCH_U: if (mem_ack) state_d = S_FETCH_L;
      S_FETCH_L: if (mem_ack) state_d = is_mem_op ? S_OPER : S_EXEC;
      S_OPER:    if (mem_ack) state_d = S_EXEC;
      S_EXEC: begin
        if (opcode == OP_HALT) state_d = S_HALT;
        else if (run)          state_d = S_FETCH_U;
        else                   state_d = S_IDLE;
      end
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pc_d   = pc_q;
    ac_d   = ac_q;
    iru_d  = iru_q;
    irl_d  = irl_q;
    opr_d  = opr_q;
    nflg_d = nflg_q;
    zflg_d = zflg_q;
    cflg_d = cflg_q;
    ac_new = ac_q;
    ac_wr  = 1'b0;

    case (state_q)
      S_FETCH_U: if (mem_ack) begin
        iru_d = mem_rdata;
        pc_d  = pc_q + PC_ONE;
      end
      S_FETCH_L: if (mem_ack) begin
        irl_d = mem_rdata;
        pc_d  = pc_q + PC_ONE;
      end
      S_OPER: if (mem_ack && (opcode != OP_STA)) begin
        opr_d = mem_rdata;
      end
      S_EXEC: begin
        case (opcode)
          OP_LDI:  begin ac_wr = 1'b1; ac_new = irl_q;         cflg_d = 1'b0; end
          OP_LDA:  begin ac_wr = 1'b1; ac_new = opr_q;         cflg_d = 1'b0; end
          OP_ADD,
          OP_ADDI: begin
            ac_wr  = 1'b1;
            ac_new = sum_ext[DATA_W-1:0];
            cflg_d = sum_ext[DATA_W];
          end
          // Carry is the inverted borrow: set when ac >= operand.
          OP_SUB:  begin
            ac_wr  = 1'b1;
            ac_new = diff_ext[DATA_W-1:0];
            cflg_d = ~diff_ext[DATA_W];
          end
          OP_AND:  begin ac_wr = 1'b1; ac_new = ac_q & opr_q;  cflg_d = 1'b0; end
          OP_OR:   begin ac_wr = 1'b1; ac_new = ac_q | opr_q;  cflg_d = 1'b0; end
          OP_XOR:  begin ac_wr = 1'b1; ac_new = ac_q ^ opr_q;  cflg_d = 1'b0; end
          OP_JMP:  pc_d = irl_addr;
          OP_JN:   if (nflg_q) pc_d = irl_addr;
          OP_JZ:   if (zflg_q) pc_d = irl_addr;
          default: ac_wr = 1'b0;
        endcase
        if (ac_wr) begin
          ac_d   = ac_new;
          zflg_d = (ac_new == '0);
          nflg_d = ac_new[DATA_W-1];
        end
      end
      default: ac_wr = 1'b0;
    endcase
  end

  always_comb begin
    mem_req   = (state_q == S_FETCH_U) || (state_q == S_FETCH_L) || (state_q == S_OPER);
    mem_we    = (state_q == S_OPER) && (opcode == OP_STA);
    mem_addr  = (state_q == S_OPER) ? irl_addr : pc_q;
    mem_wdata = ac_q;
    halted    = (state_q == S_HALT);
  end

  assign pc   = pc_q;
  assign ac   = ac_q;
  assign iru  = iru_q;
  assign irl  = irl_q;
  assign nflg = nflg_q;
  assign zflg = zflg_q;
  assign cflg = cflg_q;

endmodule
`default_nettype wire
